// File: rtl/uart_pkg.sv
`default_nettype none
// ---------------------------------------------------------------
// uart_pkg : shared receive-framer states, defaults and helpers
// Rev 1.0
// ---------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    WAIT_IDLE = 3'd0,
    IDLE      = 3'd1,
    START     = 3'd2,
    DATA      = 3'd3,
    PARITY    = 3'd4,
    STOP      = 3'd5
  } rx_state_t;

  localparam int OVERSAMPLE_DEF = 16;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_frame_if.sv
`default_nettype none
// ---------------------------------------------------------------
// uart_rx_frame_if : serial-in / word-out bundle of the RX framer
// Rev 1.0
// ---------------------------------------------------------------
interface uart_rx_frame_if #(
  parameter int DATA_BITS = 8
) ();

  logic                 baud_tick;
  logic                 rx_in;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 parity_err;
  logic                 frame_err;
  logic                 busy;

  modport master (
    output baud_tick, rx_in,
    input  rx_data, rx_valid, parity_err, frame_err, busy
  );

  modport slave (
    input  baud_tick, rx_in,
    output rx_data, rx_valid, parity_err, frame_err, busy
  );

endinterface
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ---------------------------------------------------------------
// uart_rx_sync : 2-FF line synchronizer plus 3-sample majority vote
// Rev 1.0
// ---------------------------------------------------------------
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic baud_tick_i,
  input  logic rx_i,
  output logic rx_s_o,
  output logic maj_o
);

  logic       meta_q;
  logic       rx_s_q;
  logic [1:0] hist_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      rx_s_q <= 1'b1;
      hist_q <= 2'b11;
    end else begin
      meta_q <= rx_i;
      rx_s_q <= meta_q;
      if (baud_tick_i) begin
        hist_q <= {hist_q[0], rx_s_q};
      end
    end
  end

  // On a tick, the live sample and the two previous tick samples form the vote window.
  assign rx_s_o = rx_s_q;
  assign maj_o  = maj3(hist_q[1], hist_q[0], rx_s_q);

endmodule
`default_nettype wire

// File: rtl/uart_rx_frame.sv
`default_nettype none
// ---------------------------------------------------------------
// uart_rx_frame : oversampled UART receive framer with error flags
// Rev 1.0
// ---------------------------------------------------------------
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic             clk,
  input  logic             rst,
  uart_rx_frame_if.slave   bus
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [SW-1:0] S_MID1 = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
  localparam logic          PAR_ON  = (PARITY_EN != 0);
  localparam logic          PAR_ODD = (PARITY_ODD != 0);

  rx_state_t            state_q, state_d;
  logic [SW-1:0]        s_cnt_q, s_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;

  logic rx_s;
  logic maj;

  uart_rx_sync u_sync (
    .clk         (clk),
    .rst         (rst),
    .baud_tick_i (bus.baud_tick),
    .rx_i        (bus.rx_in),
    .rx_s_o      (rx_s),
    .maj_o       (maj)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= WAIT_IDLE;
      s_cnt_q      <= '0;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      par_q        <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      s_cnt_q      <= s_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      par_q        <= par_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    s_cnt_d      = s_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    par_d        = par_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;

    if (bus.baud_tick) begin
      s_cnt_d = (s_cnt_q == S_LAST) ? '0 : s_cnt_q + 1'b1;
      unique case (state_q)
        WAIT_IDLE: begin
          s_cnt_d = '0;
          if (rx_s) state_d = IDLE;
        end
        IDLE: begin
          // The detecting tick is sample 0 of the start bit.
          s_cnt_d = '0;
          if (!rx_s) begin
            state_d = START;
            s_cnt_d = SW'(1);
          end
        end
        START: begin
          if (s_cnt_q == S_MID1 && maj) begin
            state_d = IDLE;
            s_cnt_d = '0;
          end else if (s_cnt_q == S_LAST) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
        DATA: begin
          if (s_cnt_q == S_MID1) shreg_d = {maj, shreg_q[DATA_BITS-1:1]};
          if (s_cnt_q == S_LAST) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == B_LAST) state_d = PAR_ON ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (s_cnt_q == S_MID1) par_d = maj;
          if (s_cnt_q == S_LAST) state_d = STOP;
        end
        STOP: begin
          // Decide at mid-stop so a back-to-back start edge is never missed.
          if (s_cnt_q == S_MID1) begin
            rx_valid_d   = 1'b1;
            rx_data_d    = shreg_q;
            frame_err_d  = !maj;
            parity_err_d = PAR_ON && (((^shreg_q) ^ par_q) != PAR_ODD);
            state_d      = maj ? IDLE : WAIT_IDLE;
            s_cnt_d      = '0;
          end
        end
        default: state_d = WAIT_IDLE;
      endcase
    end
  end

  assign bus.rx_data    = rx_data_q;
  assign bus.rx_valid   = rx_valid_q;
  assign bus.parity_err = parity_err_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.busy       = (state_q == START) || (state_q == DATA) ||
                          (state_q == PARITY) || (state_q == STOP);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frame.sv
`default_nettype none
// ---------------------------------------------------------------
// tb_uart_rx_frame : self-checking bench for the UART RX framer (8E1)
// Rev 1.0
// ---------------------------------------------------------------
module tb_uart_rx_frame;

  localparam int TICK_DIV   = 4;
  localparam int OVERSAMPLE = 16;
  localparam int BIT_CLKS   = OVERSAMPLE * TICK_DIV;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic [7:0] e_data;
    logic       e_perr;
    logic       e_ferr;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   check_cnt = 0;
  int   fail_cnt  = 0;
  logic prev_valid = 1'b0;
  exp_t sb[$];
  vec_t vecs[6];

  uart_rx_frame_if #(.DATA_BITS(8)) bus ();

  uart_rx_frame #(
    .DATA_BITS  (8),
    .OVERSAMPLE (OVERSAMPLE),
    .PARITY_EN  (1),
    .PARITY_ODD (0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    bus.baud_tick = 1'b0;
    forever begin
      for (int k = 0; k < TICK_DIV; k++) begin
        @(negedge clk);
        bus.baud_tick = (k == TICK_DIV - 1);
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog timeout checks=%0d", check_cnt);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every delivered word must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.rx_valid) begin
        if (sb.size() == 0) begin
          check_cnt++;
          fail_cnt++;
          $display("FAIL unexpected_valid actual=%0h expected=none", bus.rx_data);
        end else begin
          e = sb.pop_front();
          check("rx_data", bus.rx_data, e.data);
          check("parity_err", bus.parity_err, e.perr);
          check("frame_err", bus.frame_err, e.ferr);
          check("busy_at_valid", bus.busy, 0);
        end
        check("valid_one_cycle", prev_valid, 0);
      end
      prev_valid = bus.rx_valid;
    end
  end

  task automatic expect_word(input logic [7:0] d, input logic p, input logic f);
    exp_t e;
    e.data = d;
    e.perr = p;
    e.ferr = f;
    sb.push_back(e);
  endtask

  task automatic drive_bit(input logic v);
    bus.rx_in = v;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic drive_spiked_one();
    bus.rx_in = 1'b1;
    repeat (BIT_CLKS / 2) @(negedge clk);
    bus.rx_in = 1'b0;
    repeat (TICK_DIV) @(negedge clk);
    bus.rx_in = 1'b1;
    repeat (BIT_CLKS / 2 - TICK_DIV) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int spike_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == spike_bit) drive_spiked_one();
      else drive_bit(d[i]);
    end
    drive_bit(p);
    drive_bit(s);
  endtask

  initial begin
    int n;
    vecs[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[3] = '{8'h07, 1'b0, 1'b1, 8'h07, 1'b1, 1'b0};
    vecs[4] = '{8'h81, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1};
    vecs[5] = '{8'h5A, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0};

    bus.rx_in = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_rx_data", bus.rx_data, 0);
    check("reset_rx_valid", bus.rx_valid, 0);
    check("reset_parity_err", bus.parity_err, 0);
    check("reset_frame_err", bus.frame_err, 0);
    check("reset_busy", bus.busy, 0);
    rst = 1'b0;
    repeat (2 * BIT_CLKS) @(negedge clk);

    // Table-driven frames; outputs must hold their values through the idle gap.
    foreach (vecs[i]) begin
      expect_word(vecs[i].e_data, vecs[i].e_perr, vecs[i].e_ferr);
      send_frame(vecs[i].data, vecs[i].par, vecs[i].stop, -1);
      drive_bit(1'b1);
      check("hold_rx_data", bus.rx_data, vecs[i].e_data);
      check("hold_parity_err", bus.parity_err, vecs[i].e_perr);
      check("hold_frame_err", bus.frame_err, vecs[i].e_ferr);
      check("frame_delivered", sb.size(), 0);
    end

    // Break: line low for 12 bit periods delivers one zero word with frame error.
    expect_word(8'h00, 1'b0, 1'b1);
    bus.rx_in = 1'b0;
    repeat (12 * BIT_CLKS) @(negedge clk);
    check("break_delivered", sb.size(), 0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    expect_word(8'h55, 1'b0, 1'b0);
    send_frame(8'h55, 1'b0, 1'b1, -1);
    drive_bit(1'b1);
    check("after_break_delivered", sb.size(), 0);

    // Start glitch of 3 ticks: busy rises then falls, no word.
    bus.rx_in = 1'b0;
    repeat (3 * TICK_DIV) @(negedge clk);
    bus.rx_in = 1'b1;
    n = 0;
    while (!bus.busy && n < 20) begin @(negedge clk); n++; end
    check("glitch_busy_rose", bus.busy, 1);
    n = 0;
    while (bus.busy && n < 12 * TICK_DIV) begin @(negedge clk); n++; end
    check("glitch_busy_fell", bus.busy, 0);
    repeat (2 * BIT_CLKS) @(negedge clk);

    // Single-tick low spike in the middle of a '1' data bit.
    expect_word(8'hB7, 1'b0, 1'b0);
    send_frame(8'hB7, 1'b0, 1'b1, 0);
    drive_bit(1'b1);
    check("spike_delivered", sb.size(), 0);

    // Back-to-back frames with no idle gap.
    expect_word(8'h01, 1'b0, 1'b0);
    expect_word(8'hFE, 1'b0, 1'b0);
    expect_word(8'h80, 1'b0, 1'b0);
    send_frame(8'h01, 1'b1, 1'b1, -1);
    send_frame(8'hFE, 1'b1, 1'b1, -1);
    send_frame(8'h80, 1'b1, 1'b1, -1);
    drive_bit(1'b1);
    check("b2b_delivered", sb.size(), 0);

    // Reset mid-data: frame discarded, outputs cleared, next frame received.
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    bus.rx_in = 1'b0;
    repeat (BIT_CLKS / 2) @(negedge clk);
    check("busy_mid_frame", bus.busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_rx_data", bus.rx_data, 0);
    check("midrst_rx_valid", bus.rx_valid, 0);
    check("midrst_parity_err", bus.parity_err, 0);
    check("midrst_frame_err", bus.frame_err, 0);
    check("midrst_busy", bus.busy, 0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    expect_word(8'h5A, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b1, -1);

    n = 0;
    while (sb.size() != 0 && n < 2 * BIT_CLKS) begin @(negedge clk); n++; end
    check("scoreboard_drained", sb.size(), 0);
    drive_bit(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
- UART receive framer; sits directly downstream of baud_gen_rx.
- Consumes baud_gen_rx's baud_out as a 16x oversampling tick and samples the asynchronous serial line.
- Recovers start / data / optional parity / stop, presents the received word with a one-cycle valid strobe and error flags.
- Output feeds the receive FIFO / host interface.

Parameters:
- DATA_BITS, 8, payload bits per frame, legal range 5..8.
- OVERSAMPLE, 16, baud ticks per bit; must be even and at least 8.
- PARITY_EN, 1, 1 = parity bit present after data; 0 = no parity bit.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.

Ports:
- clk  input  1  system clock, same clock as baud_gen_rx.
- rst  input  1  reset; one clock, synchronous, active-high.
- baud_tick  input  1  single-clk pulse at OVERSAMPLE x baud; connected to baud_gen_rx.baud_out.
- rx_in  input  1  asynchronous serial line, idle high.
- rx_data  output  DATA_BITS  received word, LSB first on the line.
- rx_valid  output  1  one-clk pulse; rx_data and both error flags are valid in the same cycle.
- parity_err  output  1  parity mismatch on the frame just delivered.
- frame_err  output  1  stop bit sampled low on the frame just delivered.
- busy  output  1  high from start-bit detect until frame completion.

Behaviour:
- Reset:
  - rst high at a clk edge: state=WAIT_IDLE; rx_data=0, rx_valid=0, parity_err=0, frame_err=0, busy=0.
  - Sample counter, bit counter and shift register cleared.
  - A reset mid-frame discards the frame with no rx_valid.
- Input conditioning:
  - rx_in passes through a 2-FF synchronizer (rx_s) reset to 1.
  - All decisions use rx_s sampled only in clk cycles where baud_tick=1; no action occurs on non-tick cycles.
- Counters:
  - s_cnt counts 0..OVERSAMPLE-1 on ticks.
  - Bit value = majority of rx_s at s_cnt = M-1, M, M+1, where M = OVERSAMPLE/2 (7, 8, 9 at default).
- States:
  - WAIT_IDLE: stay until rx_s=1 on a tick, then go to IDLE. Prevents false starts on a stuck-low or break line.
  - IDLE: on a tick with rx_s=0, go to START with s_cnt=0 and busy=1.
  - START: at s_cnt=M+1, majority=1 is a glitch: go to IDLE with busy=0. Otherwise continue; at s_cnt=OVERSAMPLE-1 go to DATA with bit_cnt=0.
  - DATA: at s_cnt=M+1, shift the majority bit in, LSB first. At s_cnt=OVERSAMPLE-1, increment bit_cnt; after DATA_BITS bits go to PARITY if PARITY_EN, else STOP.
  - PARITY: at s_cnt=M+1, capture the parity bit; at s_cnt=OVERSAMPLE-1 go to STOP.
  - STOP: at s_cnt=M+1 the frame completes; the block does not wait for the end of the stop bit, so it resynchronises to back-to-back frames.
    - Stop majority=1: go to IDLE.
    - Stop majority=0: go to WAIT_IDLE.
- Output timing:
  - On the clk edge after the stop-decision tick, rx_valid=1 for exactly one clk.
  - In that cycle rx_data = assembled word.
  - parity_err = (XOR of data bits XOR parity bit) != PARITY_ODD; forced 0 when PARITY_EN=0.
  - frame_err = (stop majority == 0).
- Flag and busy rules:
  - rx_data, parity_err and frame_err hold until the next rx_valid.
  - busy deasserts in the same cycle rx_valid asserts.
- Frames with errors are still delivered (rx_valid=1); the consumer decides what to do with them.
- Break condition (all-zero data and stop low): delivered as data=0 with frame_err=1; no further frames until the line returns high.
- baud_tick asserted in consecutive clk cycles is legal; each tick is counted.

Decomposition:
- Package uart_pkg holds:
  - rx_state_t enum {WAIT_IDLE, IDLE, START, DATA, PARITY, STOP};
  - constant OVERSAMPLE_DEF=16;
  - function maj3.
- Sub-module uart_rx_sync: 2-FF synchronizer, reset value 1, then the 3-sample majority shift register advanced on baud_tick.
- FSM, counters and output registers live in uart_rx_frame.

Test Plan:
- Clean frame: baud_tick every 4 clk, 8E1, send 0xA5 (parity bit 0) -> one rx_valid pulse, rx_data=0xA5, parity_err=0, frame_err=0, busy high about 10.5 bit periods.
- Parity error: send 0x3C with parity bit 1 under even parity -> rx_data=0x3C, parity_err=1, frame_err=0.
- Framing error / break: hold rx_in low for 12 bit periods -> rx_data=0x00, frame_err=1, no second frame until rx_in high; then send 0x55 -> received correctly.
- Start glitch and noise:
  - rx_in low for 3 ticks only -> no rx_valid, busy returns to 0 by tick 9.
  - Single-tick low spike at sample tick 8 of a data bit that should be 1 -> majority keeps 1, correct byte.
- Back-to-back and reset: send 0x01, 0xFE, 0x80 with zero idle gap -> three rx_valid pulses with correct values. Assert rst for 1 clk mid-data of a fourth frame -> all outputs 0, no rx_valid, and a following frame 0x5A is received.
